// File: rtl/jogo_pkg.sv
// Shared definitions for the game input path: detector FSM state codes,
// default switch count and small bit-vector helpers.
// The INVALIDA state only exists when DETECTOR_JOGADA_INVALIDA_EN is defined.
package jogo_pkg;

  localparam int unsigned N_CHAVES_PADRAO = 4;
  // Helpers operate on a fixed wide vector; callers zero-extend and truncate.
  localparam int unsigned MAX_CHAVES = 32;

  // State codes double as the db_estado debug value.
  typedef enum logic [2:0] {
    ESPERA    = 3'd0,
    FILTRANDO = 3'd1,
    EMITE     = 3'd2,
`ifdef DETECTOR_JOGADA_INVALIDA_EN
    INVALIDA  = 3'd3,
`endif
    SEGURANDO = 3'd4
  } estado_t;

  // True when exactly one bit is set.
  function automatic logic eh_one_hot(input logic [MAX_CHAVES-1:0] x);
    return (x != '0) && ((x & (x - MAX_CHAVES'(1))) == '0);
  endfunction

  // Isolates the lowest set bit (zero stays zero).
  function automatic logic [MAX_CHAVES-1:0] bit_menor(input logic [MAX_CHAVES-1:0] x);
    return x & (~x + MAX_CHAVES'(1));
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
// Ports: clock, reset (sync, active-high), d (async in), q (synchronized out).
module sincronizador #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/detector_jogada.sv
// Switch conditioner: synchronizes and debounces raw switches, reports one
// registered one-hot jogada plus a single-cycle tem_jogada per physical press.
// Multi-hot presses are rejected (jogada_invalida) when
// DETECTOR_JOGADA_INVALIDA_EN is defined; otherwise they are reduced to their
// lowest set bit. A held key never repeats and a key held through reset is
// ignored until released.
// Ports: clock, reset (sync, active-high), habilita (reporting enable),
//        chaves (raw switches), jogada (last accepted code), tem_jogada
//        (press strobe), jogada_invalida (multi-hot strobe), db_estado (state).
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int unsigned N_CHAVES        = N_CHAVES_PADRAO,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_CHAVES-1:0] chaves,
  output logic [N_CHAVES-1:0] jogada,
  output logic                tem_jogada,
  output logic                jogada_invalida,
  output logic [2:0]          db_estado
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [N_CHAVES-1:0] s;
  logic [N_CHAVES-1:0] v, v_prox;
  logic [N_CHAVES-1:0] jogada_prox;
  logic [CNT_W-1:0]    cnt, cnt_prox;
  estado_t             estado, estado_prox;
  logic                tem_prox;

  sincronizador #(.W(N_CHAVES)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (chaves),
    .q     (s)
  );

  // State, candidate, counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= SEGURANDO;
      v          <= '0;
      cnt        <= '0;
      jogada     <= '0;
      tem_jogada <= 1'b0;
    end else begin
      estado     <= estado_prox;
      v          <= v_prox;
      cnt        <= cnt_prox;
      jogada     <= jogada_prox;
      tem_jogada <= tem_prox;
    end
  end

  // Next-state, candidate and counter update.
  always_comb begin
    estado_prox = estado;
    v_prox      = v;
    cnt_prox    = cnt;
    jogada_prox = jogada;
    unique case (estado)
      ESPERA: begin
        if (s != '0) begin
          v_prox      = s;
          cnt_prox    = CNT_W'(1);
          estado_prox = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (s == '0) begin
          estado_prox = ESPERA;
        end else if (s != v) begin
          // A different code restarts the stability window.
          v_prox   = s;
          cnt_prox = CNT_W'(1);
        end else if (cnt == CNT_MAX) begin
          cnt_prox = '0;
          if (!habilita) begin
            estado_prox = SEGURANDO;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
          end else if (eh_one_hot(MAX_CHAVES'(v))) begin
            estado_prox = EMITE;
            jogada_prox = v;
          end else begin
            estado_prox = INVALIDA;
          end
`else
          end else begin
            estado_prox = EMITE;
            jogada_prox = N_CHAVES'(bit_menor(MAX_CHAVES'(v)));
          end
`endif
        end else begin
          cnt_prox = cnt + CNT_W'(1);
        end
      end
      EMITE: begin
        estado_prox = SEGURANDO;
        cnt_prox    = '0;
      end
`ifdef DETECTOR_JOGADA_INVALIDA_EN
      INVALIDA: begin
        estado_prox = SEGURANDO;
        cnt_prox    = '0;
      end
`endif
      SEGURANDO: begin
        // Leave only after DEBOUNCE_CYCLES consecutive all-released samples.
        if (s != '0) begin
          cnt_prox = '0;
        end else if (cnt + CNT_W'(1) == CNT_MAX) begin
          cnt_prox    = '0;
          estado_prox = ESPERA;
        end else begin
          cnt_prox = cnt + CNT_W'(1);
        end
      end
      default: begin
        estado_prox = SEGURANDO;
        cnt_prox    = '0;
      end
    endcase
    tem_prox = (estado_prox == EMITE);
  end

`ifdef DETECTOR_JOGADA_INVALIDA_EN
  logic inv_prox;
  assign inv_prox = (estado_prox == INVALIDA);

  always_ff @(posedge clock) begin
    if (reset) begin
      jogada_invalida <= 1'b0;
    end else begin
      jogada_invalida <= inv_prox;
    end
  end
`else
  assign jogada_invalida = 1'b0;
`endif

  assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with default parameters (4 switches,
// debounce of 4 samples). Inputs change 1 time unit after a rising edge, so
// the following edge is the first one that samples them.
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic [2:0] db_estado;

  int n_vec;
  int n_err;
  int n_tem;
  int n_inv;
  int base_tem;
  int base_inv;

  detector_jogada #(.N_CHAVES(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .chaves          (chaves),
    .jogada          (jogada),
    .tem_jogada      (tem_jogada),
    .jogada_invalida (jogada_invalida),
    .db_estado       (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n edges, sampling 1 unit after each and tallying strobes.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (tem_jogada === 1'b1) n_tem++;
      if (jogada_invalida === 1'b1) n_inv++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; habilita = 1'b1; chaves = 4'b0000;
    step(2);
    reset = 1'b0;
    n_vec++;
    if (jogada !== 4'b0000 || tem_jogada !== 1'b0 || jogada_invalida !== 1'b0 || db_estado !== 3'd4) begin
      n_err++;
      $display("FAIL reset_values: got jogada=%b tem=%b inv=%b estado=%0d expected 0000 0 0 4",
               jogada, tem_jogada, jogada_invalida, db_estado);
    end
    step(1);
    n_vec++;
    if (db_estado !== 3'd4) begin
      n_err++; $display("FAIL reset_hold_segurando: got %0d expected 4", db_estado);
    end
    step(5);
    n_vec++;
    if (db_estado !== 3'd0) begin
      n_err++; $display("FAIL reset_to_espera: got %0d expected 0", db_estado);
    end
  endtask

  task automatic test_press_simple;
    base_tem = n_tem;
    chaves = 4'b0001;
    step(6);
    n_vec++;
    if (tem_jogada !== 1'b0) begin
      n_err++; $display("FAIL press_early: got tem=%b expected 0", tem_jogada);
    end
    step(1);
    n_vec++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b0001 || db_estado !== 3'd2) begin
      n_err++;
      $display("FAIL press_latency: got tem=%b jogada=%b estado=%0d expected 1 0001 2",
               tem_jogada, jogada, db_estado);
    end
    step(1);
    n_vec++;
    if (tem_jogada !== 1'b0 || db_estado !== 3'd4) begin
      n_err++; $display("FAIL press_width: got tem=%b estado=%0d expected 0 4", tem_jogada, db_estado);
    end
    step(2);
    chaves = 4'b0000;
    step(8);
    n_vec++;
    if (n_tem - base_tem !== 1 || jogada !== 4'b0001 || db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL press_release: got pulses=%0d jogada=%b estado=%0d expected 1 0001 0",
               n_tem - base_tem, jogada, db_estado);
    end
  endtask

  task automatic test_glitch;
    base_tem = n_tem;
    chaves = 4'b0100;
    step(3);
    chaves = 4'b0000;
    step(10);
    n_vec++;
    if (n_tem - base_tem !== 0 || jogada !== 4'b0001 || db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL short_glitch: got pulses=%0d jogada=%b estado=%0d expected 0 0001 0",
               n_tem - base_tem, jogada, db_estado);
    end
  endtask

  task automatic test_bounce;
    base_tem = n_tem;
    chaves = 4'b0010; step(2);
    chaves = 4'b0000; step(2);
    chaves = 4'b0010; step(2);
    n_vec++;
    if (n_tem - base_tem !== 0) begin
      n_err++; $display("FAIL bounce_early: got pulses=%0d expected 0", n_tem - base_tem);
    end
    step(10);
    chaves = 4'b0000;
    step(8);
    n_vec++;
    if (n_tem - base_tem !== 1 || jogada !== 4'b0010 || db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL bounce_press: got pulses=%0d jogada=%b estado=%0d expected 1 0010 0",
               n_tem - base_tem, jogada, db_estado);
    end
  endtask

  task automatic test_multihot;
    base_tem = n_tem; base_inv = n_inv;
    chaves = 4'b0101;
    step(7);
    n_vec++;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
    if (jogada_invalida !== 1'b1 || tem_jogada !== 1'b0 || jogada !== 4'b0010 || db_estado !== 3'd3) begin
      n_err++;
      $display("FAIL multihot_invalida: got inv=%b tem=%b jogada=%b estado=%0d expected 1 0 0010 3",
               jogada_invalida, tem_jogada, jogada, db_estado);
    end
`else
    if (tem_jogada !== 1'b1 || jogada_invalida !== 1'b0 || jogada !== 4'b0001 || db_estado !== 3'd2) begin
      n_err++;
      $display("FAIL multihot_lowbit: got tem=%b inv=%b jogada=%b estado=%0d expected 1 0 0001 2",
               tem_jogada, jogada_invalida, jogada, db_estado);
    end
`endif
    step(3);
    chaves = 4'b0000;
    step(8);
    n_vec++;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
    if (n_inv - base_inv !== 1 || n_tem - base_tem !== 0 || jogada !== 4'b0010) begin
      n_err++;
      $display("FAIL multihot_count: got inv=%0d tem=%0d jogada=%b expected 1 0 0010",
               n_inv - base_inv, n_tem - base_tem, jogada);
    end
`else
    if (n_inv - base_inv !== 0 || n_tem - base_tem !== 1 || jogada !== 4'b0001) begin
      n_err++;
      $display("FAIL multihot_count: got inv=%0d tem=%0d jogada=%b expected 0 1 0001",
               n_inv - base_inv, n_tem - base_tem, jogada);
    end
`endif
  endtask

  task automatic test_held_reset;
    chaves = 4'b1000;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    base_tem = n_tem;
    n_vec++;
    if (jogada !== 4'b0000 || db_estado !== 3'd4 || tem_jogada !== 1'b0) begin
      n_err++;
      $display("FAIL held_reset_values: got jogada=%b estado=%0d tem=%b expected 0000 4 0",
               jogada, db_estado, tem_jogada);
    end
    step(10);
    n_vec++;
    if (n_tem - base_tem !== 0 || db_estado !== 3'd4) begin
      n_err++;
      $display("FAIL held_no_repeat: got pulses=%0d estado=%0d expected 0 4", n_tem - base_tem, db_estado);
    end
    chaves = 4'b0000;
    step(6);
    n_vec++;
    if (db_estado !== 3'd0) begin
      n_err++; $display("FAIL release_latency: got estado=%0d expected 0", db_estado);
    end
    chaves = 4'b1000;
    step(7);
    n_vec++;
    if (tem_jogada !== 1'b1 || jogada !== 4'b1000) begin
      n_err++; $display("FAIL repress: got tem=%b jogada=%b expected 1 1000", tem_jogada, jogada);
    end
    step(3);
    chaves = 4'b0000;
    step(8);
    n_vec++;
    if (n_tem - base_tem !== 1) begin
      n_err++; $display("FAIL repress_count: got pulses=%0d expected 1", n_tem - base_tem);
    end
  endtask

  task automatic test_habilita;
    base_tem = n_tem;
    habilita = 1'b0;
    chaves = 4'b0100;
    step(7);
    n_vec++;
    if (tem_jogada !== 1'b0 || db_estado !== 3'd4 || jogada !== 4'b1000) begin
      n_err++;
      $display("FAIL habilita_swallow: got tem=%b estado=%0d jogada=%b expected 0 4 1000",
               tem_jogada, db_estado, jogada);
    end
    habilita = 1'b1;
    step(3);
    chaves = 4'b0000;
    step(8);
    n_vec++;
    if (n_tem - base_tem !== 0 || db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL habilita_count: got pulses=%0d estado=%0d expected 0 0", n_tem - base_tem, db_estado);
    end
  endtask

  task automatic test_reset_mid;
    base_tem = n_tem;
    chaves = 4'b0001;
    step(4);
    n_vec++;
    if (db_estado !== 3'd1) begin
      n_err++; $display("FAIL mid_filtrando: got estado=%0d expected 1", db_estado);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_vec++;
    if (jogada !== 4'b0000 || tem_jogada !== 1'b0 || jogada_invalida !== 1'b0 || db_estado !== 3'd4) begin
      n_err++;
      $display("FAIL mid_reset_values: got jogada=%b tem=%b inv=%b estado=%0d expected 0000 0 0 4",
               jogada, tem_jogada, jogada_invalida, db_estado);
    end
    step(8);
    chaves = 4'b0000;
    step(8);
    n_vec++;
    if (n_tem - base_tem !== 0 || jogada !== 4'b0000 || db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL mid_reset_after: got pulses=%0d jogada=%b estado=%0d expected 0 0000 0",
               n_tem - base_tem, jogada, db_estado);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_tem = 0; n_inv = 0;
    base_tem = 0; base_inv = 0;
    reset = 1'b1; habilita = 1'b1; chaves = 4'b0000;
    test_reset;
    test_press_simple;
    test_glitch;
    test_bounce;
    test_multihot;
    test_held_reset;
    test_habilita;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
